// File: rtl/pic_intr_acceptor_if.sv
// Handshake bundle between the PIC, the IVT memory port, the CPU core and the acceptor.
// The slave modport is the acceptor's view; master is the environment driving it.
interface pic_intr_acceptor_if #(
    parameter int unsigned ADDR_W = 20
);
    logic              interrupt_valid;
    logic [7:0]        interrupt_data;
    logic              interrupt_ack;
    logic              irq_enable;

    logic              m_axis_mem_req_tvalid;
    logic              m_axis_mem_req_tready;
    logic [ADDR_W-1:0] m_axis_mem_req_tdata;

    logic              s_axis_mem_res_tvalid;
    logic              s_axis_mem_res_tready;
    logic [15:0]       s_axis_mem_res_tdata;

    logic              m_axis_intr_tvalid;
    logic              m_axis_intr_tready;
    logic [39:0]       m_axis_intr_tdata;

    modport master (
        output interrupt_valid, interrupt_data, irq_enable,
        output m_axis_mem_req_tready,
        output s_axis_mem_res_tvalid, s_axis_mem_res_tdata,
        output m_axis_intr_tready,
        input  interrupt_ack,
        input  m_axis_mem_req_tvalid, m_axis_mem_req_tdata,
        input  s_axis_mem_res_tready,
        input  m_axis_intr_tvalid, m_axis_intr_tdata
    );

    modport slave (
        input  interrupt_valid, interrupt_data, irq_enable,
        input  m_axis_mem_req_tready,
        input  s_axis_mem_res_tvalid, s_axis_mem_res_tdata,
        input  m_axis_intr_tready,
        output interrupt_ack,
        output m_axis_mem_req_tvalid, m_axis_mem_req_tdata,
        output s_axis_mem_res_tready,
        output m_axis_intr_tvalid, m_axis_intr_tdata
    );
endinterface

// File: rtl/pic_intr_acceptor.sv
// Accepts a PIC vector, fetches its real-mode IVT entry (IP then CS) and hands
// {vector, CS, IP} to the CPU core. All outputs come straight from registers.
module pic_intr_acceptor #(
    parameter int unsigned       ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] IVT_BASE = '0
) (
    input logic                clk,
    input logic                resetn,
    pic_intr_acceptor_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_RD_IP_REQ,
        S_RD_IP_RES,
        S_RD_CS_REQ,
        S_RD_CS_RES,
        S_OUT
    } state_t;

    state_t            state_q;
    logic [7:0]        vector_q;
    logic [15:0]       ip_q;
    logic              ack_q;
    logic              req_tvalid_q;
    logic [ADDR_W-1:0] req_tdata_q;
    logic              res_tready_q;
    logic              intr_tvalid_q;
    logic [39:0]       intr_tdata_q;

    logic [ADDR_W-1:0] ip_addr_d;
    logic [ADDR_W-1:0] cs_addr_d;

    // Each IVT entry is 4 bytes; the add wraps naturally at ADDR_W bits.
    assign ip_addr_d = IVT_BASE + ADDR_W'({vector_q, 2'b00});
    assign cs_addr_d = req_tdata_q + ADDR_W'(2);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            vector_q      <= '0;
            ip_q          <= '0;
            ack_q         <= 1'b0;
            req_tvalid_q  <= 1'b0;
            req_tdata_q   <= '0;
            res_tready_q  <= 1'b0;
            intr_tvalid_q <= 1'b0;
            intr_tdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.interrupt_valid && bus.irq_enable) begin
                        ack_q    <= 1'b1;
                        vector_q <= bus.interrupt_data;
                        state_q  <= S_ACK;
                    end
                end
                // Ack lasts exactly this cycle; the PIC drops valid on the same edge.
                S_ACK: begin
                    ack_q        <= 1'b0;
                    req_tvalid_q <= 1'b1;
                    req_tdata_q  <= ip_addr_d;
                    state_q      <= S_RD_IP_REQ;
                end
                S_RD_IP_REQ: begin
                    if (bus.m_axis_mem_req_tready) begin
                        req_tvalid_q <= 1'b0;
                        res_tready_q <= 1'b1;
                        state_q      <= S_RD_IP_RES;
                    end
                end
                S_RD_IP_RES: begin
                    if (bus.s_axis_mem_res_tvalid) begin
                        ip_q         <= bus.s_axis_mem_res_tdata;
                        res_tready_q <= 1'b0;
                        req_tvalid_q <= 1'b1;
                        req_tdata_q  <= cs_addr_d;
                        state_q      <= S_RD_CS_REQ;
                    end
                end
                S_RD_CS_REQ: begin
                    if (bus.m_axis_mem_req_tready) begin
                        req_tvalid_q <= 1'b0;
                        res_tready_q <= 1'b1;
                        state_q      <= S_RD_CS_RES;
                    end
                end
                S_RD_CS_RES: begin
                    if (bus.s_axis_mem_res_tvalid) begin
                        res_tready_q  <= 1'b0;
                        intr_tvalid_q <= 1'b1;
                        intr_tdata_q  <= {vector_q, bus.s_axis_mem_res_tdata, ip_q};
                        state_q       <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.m_axis_intr_tready) begin
                        intr_tvalid_q <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    ack_q         <= 1'b0;
                    req_tvalid_q  <= 1'b0;
                    res_tready_q  <= 1'b0;
                    intr_tvalid_q <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.interrupt_ack         = ack_q;
    assign bus.m_axis_mem_req_tvalid = req_tvalid_q;
    assign bus.m_axis_mem_req_tdata  = req_tdata_q;
    assign bus.s_axis_mem_res_tready = res_tready_q;
    assign bus.m_axis_intr_tvalid    = intr_tvalid_q;
    assign bus.m_axis_intr_tdata     = intr_tdata_q;

endmodule

// File: tb/tb_pic_intr_acceptor.sv
// Directed bench: PIC, IVT memory and CPU models around two acceptors
// (IVT at 0x00000, and at 0xFFFFC to exercise address wrap).
module tb_pic_intr_acceptor;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    pic_intr_acceptor_if #(.ADDR_W(20)) ifa ();
    pic_intr_acceptor_if #(.ADDR_W(20)) ifb ();

    pic_intr_acceptor #(.ADDR_W(20), .IVT_BASE(20'h00000)) dut_a (
        .clk(clk), .resetn(resetn), .bus(ifa)
    );
    pic_intr_acceptor #(.ADDR_W(20), .IVT_BASE(20'hFFFFC)) dut_b (
        .clk(clk), .resetn(resetn), .bus(ifb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // ---------------- memory model for dut_a ----------------
    logic [15:0] mem_a [int];
    logic [19:0] req_log [$];
    int req_stall = 0;
    int res_delay = 0;
    int addr_unstable = 0;
    int double_req = 0;

    initial begin : mem_a_model
        bit req_fire, res_fire, pend, held;
        logic [19:0] fire_addr, pend_addr, held_addr;
        int stall_cnt, dly_cnt;
        req_fire = 0; res_fire = 0; pend = 0; held = 0;
        fire_addr = '0; pend_addr = '0; held_addr = '0;
        stall_cnt = 0; dly_cnt = 0;
        ifa.m_axis_mem_req_tready = 1'b0;
        ifa.s_axis_mem_res_tvalid = 1'b0;
        ifa.s_axis_mem_res_tdata  = '0;
        forever begin
            @(posedge clk); #1;
            if (!resetn) begin
                req_fire = 0; res_fire = 0; pend = 0; held = 0;
                stall_cnt = 0; dly_cnt = 0;
                ifa.m_axis_mem_req_tready = 1'b0;
                ifa.s_axis_mem_res_tvalid = 1'b0;
            end else begin
                if (req_fire) begin
                    pend = 1; pend_addr = fire_addr; dly_cnt = 0; held = 0;
                end
                if (res_fire) pend = 0;
                req_fire = 0;
                res_fire = 0;
                if (ifa.m_axis_mem_req_tvalid && pend) double_req++;
                if (ifa.m_axis_mem_req_tvalid && held && ifa.m_axis_mem_req_tdata !== held_addr)
                    addr_unstable++;
                ifa.m_axis_mem_req_tready = 1'b0;
                if (ifa.m_axis_mem_req_tvalid && !pend) begin
                    if (stall_cnt < req_stall) begin
                        stall_cnt++;
                        held = 1;
                        held_addr = ifa.m_axis_mem_req_tdata;
                    end else begin
                        ifa.m_axis_mem_req_tready = 1'b1;
                        req_fire = 1;
                        fire_addr = ifa.m_axis_mem_req_tdata;
                        req_log.push_back(fire_addr);
                        stall_cnt = 0;
                    end
                end
                ifa.s_axis_mem_res_tvalid = 1'b0;
                if (pend) begin
                    if (dly_cnt < res_delay) begin
                        dly_cnt++;
                    end else begin
                        ifa.s_axis_mem_res_tvalid = 1'b1;
                        ifa.s_axis_mem_res_tdata = mem_a.exists(int'(pend_addr)) ?
                                                   mem_a[int'(pend_addr)] : 16'hDEAD;
                        res_fire = ifa.s_axis_mem_res_tready;
                    end
                end
            end
        end
    end

    // ---------------- zero-wait memory model for dut_b ----------------
    logic [19:0] b_log [$];
    initial begin : mem_b_model
        logic [19:0] last;
        last = '0;
        ifb.m_axis_mem_req_tready = 1'b1;
        ifb.s_axis_mem_res_tvalid = 1'b0;
        ifb.s_axis_mem_res_tdata  = '0;
        forever begin
            @(posedge clk); #1;
            if (resetn && ifb.m_axis_mem_req_tvalid) begin
                last = ifb.m_axis_mem_req_tdata;
                b_log.push_back(last);
            end
            ifb.s_axis_mem_res_tvalid = resetn && ifb.s_axis_mem_res_tready;
            ifb.s_axis_mem_res_tdata  = (last == 20'h00000) ? 16'h5555 :
                                        (last == 20'h00002) ? 16'h6666 : 16'hDEAD;
        end
    end

    // ---------------- ack pulse counters ----------------
    int ack_cnt = 0;
    int ack_b_cnt = 0;
    initial begin : ack_mon
        forever begin
            @(posedge clk); #1;
            if (ifa.interrupt_ack === 1'b1) ack_cnt++;
            if (ifb.interrupt_ack === 1'b1) ack_b_cnt++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic wait_ack(input string tag, input int exp_lat);
        int n = 0;
        while (ifa.interrupt_ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n), 64'(exp_lat));
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int n = 0;
        while (ifa.m_axis_intr_tvalid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n), 64'(exp_lat));
    endtask

    task automatic pic_raise(input logic [7:0] v, input logic en);
        ifa.interrupt_valid = 1'b1;
        ifa.interrupt_data  = v;
        ifa.irq_enable      = en;
    endtask

    function automatic logic [63:0] outs_a();
        return {ifa.interrupt_ack, ifa.m_axis_mem_req_tvalid, ifa.m_axis_mem_req_tdata,
                ifa.s_axis_mem_res_tready, ifa.m_axis_intr_tvalid, ifa.m_axis_intr_tdata};
    endfunction

    function automatic logic [63:0] outs_b();
        return {ifb.interrupt_ack, ifb.m_axis_mem_req_tvalid, ifb.m_axis_mem_req_tdata,
                ifb.s_axis_mem_res_tready, ifb.m_axis_intr_tvalid, ifb.m_axis_intr_tdata};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin : main
        int acks0;
        int n;
        ifa.interrupt_valid = 1'b0; ifa.interrupt_data = '0; ifa.irq_enable = 1'b0;
        ifa.m_axis_intr_tready = 1'b1;
        ifb.interrupt_valid = 1'b0; ifb.interrupt_data = '0; ifb.irq_enable = 1'b0;
        ifb.m_axis_intr_tready = 1'b1;
        mem_a[32'h20] = 16'h1234; mem_a[32'h22] = 16'hF000;
        mem_a[32'h24] = 16'hABCD; mem_a[32'h26] = 16'h1000;
        mem_a[32'h1C0] = 16'h0100; mem_a[32'h1C2] = 16'hC800;
        mem_a[32'h2C] = 16'h2222; mem_a[32'h2E] = 16'h3333;
        mem_a[32'h34] = 16'h4444; mem_a[32'h36] = 16'h5555;
        mem_a[32'h30] = 16'h7777; mem_a[32'h32] = 16'h8888;

        repeat (2) @(negedge clk);
        chk("reset_outs_a", outs_a(), 64'h0);
        chk("reset_outs_b", outs_b(), 64'h0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // 1: vector 0x08, zero-wait, minimum latency
        req_log.delete();
        pic_raise(8'h08, 1'b1);
        wait_ack("t1_ack_lat", 1);
        ifa.interrupt_valid = 1'b0;
        wait_result("t1_res_lat", 5);
        chk("t1_tdata", 64'(ifa.m_axis_intr_tdata), 64'h08_F000_1234);
        @(negedge clk);
        chk("t1_tvalid_drop", 64'(ifa.m_axis_intr_tvalid), 64'h0);
        chk("t1_ack_count", 64'(ack_cnt), 64'd1);
        chk("t1_req_count", 64'(req_log.size()), 64'd2);
        chk("t1_addr_ip", 64'(req_log[0]), 64'h00020);
        chk("t1_addr_cs", 64'(req_log[1]), 64'h00022);

        // 2: pending vector held off by irq_enable
        req_log.delete();
        acks0 = ack_cnt;
        pic_raise(8'h09, 1'b0);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (ifa.m_axis_mem_req_tvalid === 1'b1) n++;
        end
        chk("t2_no_ack", 64'(ack_cnt - acks0), 64'd0);
        chk("t2_no_req", 64'(n), 64'd0);
        ifa.irq_enable = 1'b1;
        wait_ack("t2_ack_lat", 1);
        ifa.interrupt_valid = 1'b0;
        wait_result("t2_res_lat", 5);
        chk("t2_tdata", 64'(ifa.m_axis_intr_tdata), 64'h09_1000_ABCD);
        @(negedge clk);
        chk("t2_addr_ip", 64'(req_log[0]), 64'h00024);

        // 3: request stall and response delay
        req_log.delete();
        req_stall = 3;
        res_delay = 2;
        pic_raise(8'h70, 1'b1);
        wait_ack("t3_ack_lat", 1);
        ifa.interrupt_valid = 1'b0;
        n = 0;
        while (ifa.m_axis_intr_tvalid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t3_done", 64'(n < 100), 64'd1);
        chk("t3_tdata", 64'(ifa.m_axis_intr_tdata), 64'h70_C800_0100);
        @(negedge clk);
        chk("t3_addr_ip", 64'(req_log[0]), 64'h001C0);
        chk("t3_addr_cs", 64'(req_log[1]), 64'h001C2);
        chk("t3_addr_stable", 64'(addr_unstable), 64'd0);
        chk("t3_single_outstanding", 64'(double_req), 64'd0);
        req_stall = 0;
        res_delay = 0;

        // 4: CPU back-pressure while the PIC reasserts
        req_log.delete();
        ifa.m_axis_intr_tready = 1'b0;
        pic_raise(8'h0B, 1'b1);
        wait_ack("t4a_ack_lat", 1);
        ifa.interrupt_valid = 1'b0;
        wait_result("t4a_res_lat", 5);
        pic_raise(8'h09, 1'b1);
        acks0 = ack_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t4_hold_tvalid_%0d", i), 64'(ifa.m_axis_intr_tvalid), 64'h1);
        end
        chk("t4_hold_tdata", 64'(ifa.m_axis_intr_tdata), 64'h0B_3333_2222);
        chk("t4_no_ack_while_held", 64'(ack_cnt - acks0), 64'd0);
        ifa.m_axis_intr_tready = 1'b1;
        wait_ack("t4b_ack_lat", 2);
        ifa.interrupt_valid = 1'b0;
        wait_result("t4b_res_lat", 5);
        chk("t4b_tdata", 64'(ifa.m_axis_intr_tdata), 64'h09_1000_ABCD);
        @(negedge clk);

        // 5: reset while waiting for the CS word
        req_log.delete();
        res_delay = 4;
        pic_raise(8'h0D, 1'b1);
        wait_ack("t5a_ack_lat", 1);
        ifa.interrupt_valid = 1'b0;
        n = 0;
        while (!(req_log.size() == 2 && ifa.s_axis_mem_res_tready === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_in_cs_res", 64'(n < 100), 64'd1);
        #1 resetn = 1'b0;
        #1 chk("t5_async_clear", outs_a(), 64'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        res_delay = 0;
        req_log.delete();
        @(negedge clk);
        pic_raise(8'h0C, 1'b1);
        wait_ack("t5b_ack_lat", 1);
        ifa.interrupt_valid = 1'b0;
        wait_result("t5b_res_lat", 5);
        chk("t5b_tdata", 64'(ifa.m_axis_intr_tdata), 64'h0C_8888_7777);
        @(negedge clk);
        chk("t5b_addr_ip", 64'(req_log[0]), 64'h00030);
        chk("t5b_addr_cs", 64'(req_log[1]), 64'h00032);

        // 6: IVT base near the top of memory wraps to 0
        b_log.delete();
        ifb.interrupt_valid = 1'b1;
        ifb.interrupt_data  = 8'h01;
        ifb.irq_enable      = 1'b1;
        n = 0;
        while (ifb.interrupt_ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_ack_lat", 64'(n), 64'd1);
        ifb.interrupt_valid = 1'b0;
        n = 0;
        while (ifb.m_axis_intr_tvalid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_res_lat", 64'(n), 64'd5);
        chk("t6_tdata", 64'(ifb.m_axis_intr_tdata), 64'h01_6666_5555);
        @(negedge clk);
        chk("t6_req_count", 64'(b_log.size()), 64'd2);
        chk("t6_addr_ip", 64'(b_log[0]), 64'h00000);
        chk("t6_addr_cs", 64'(b_log[1]), 64'h00002);
        chk("t6_ack_count", 64'(ack_b_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pic_intr_acceptor.md
Name: pic_intr_acceptor

Overview:
- CPU-side consumer of the PIC interrupt handshake (interrupt_valid / interrupt_data / interrupt_ack).
- Accepts a pending vector when the CPU allows it and pulses the acknowledge.
- Reads the real-mode IVT entry (IP, then CS) over a memory request/response stream.
- Presents {vector, CS, IP} to the CPU core on an AXI-Stream-style output.

Parameters:
- ADDR_W, 20, memory byte-address width.
- IVT_BASE, 20'h00000, byte base address of the interrupt vector table.

Ports:
- clk  in  1  CPU clock.
- resetn  in  1  reset, asynchronous, active-low.
- interrupt_valid  in  1  PIC has a vector pending.
- interrupt_data  in  8  PIC vector number.
- interrupt_ack  out  1  one-cycle accept pulse to the PIC.
- irq_enable  in  1  CPU IF flag AND instruction boundary; acceptance is allowed only when high.
- m_axis_mem_req_tvalid  out  1  memory read request valid.
- m_axis_mem_req_tready  in  1  memory request ready.
- m_axis_mem_req_tdata  out  ADDR_W  byte address of the 16-bit read.
- s_axis_mem_res_tvalid  in  1  read data valid.
- s_axis_mem_res_tready  out  1  read data ready.
- s_axis_mem_res_tdata  in  16  read data word.
- m_axis_intr_tvalid  out  1  vector result valid.
- m_axis_intr_tready  in  1  CPU accepts the result.
- m_axis_intr_tdata  out  40  {vector[39:32], cs[31:16], ip[15:0]}.

Behaviour:
- Reset: async, active-low. On reset, state=IDLE and all outputs are 0 (interrupt_ack, both tvalids, s_axis_mem_res_tready, every tdata).
- IDLE:
  - Transition when interrupt_valid=1 and irq_enable=1.
  - Next cycle: interrupt_ack=1 for exactly one cycle; vector latched from interrupt_data; state -> RD_IP_REQ.
  - interrupt_ack is registered, never combinational.
- Ack state: ack is high only during this one cycle, so the PIC's valid, which drops on that edge, is never accepted twice.
- RD_IP_REQ:
  - m_axis_mem_req_tvalid=1, tdata = IVT_BASE + {vector, 2'b00} (ADDR_W-bit add, wraps modulo 2^ADDR_W).
  - tvalid and tdata are held stable until tready=1, then state -> RD_IP_RES.
- RD_IP_RES:
  - s_axis_mem_res_tready=1; on tvalid, latch ip.
  - State -> RD_CS_REQ.
- RD_CS_REQ: as RD_IP_REQ with address = IP address + 2.
- RD_CS_RES: as RD_IP_RES, latching cs; state -> OUT.
- OUT:
  - m_axis_intr_tvalid=1 and tdata stable until tready=1, then state -> IDLE.
  - Earliest re-acceptance is the cycle after the handshake.
- s_axis_mem_res_tready is 0 outside the RES states. Responses arriving then are not consumed; the responder must hold them.
- Request tvalid may be asserted in the same cycle as the state entry. There is no combinational path from tready to tvalid.
- irq_enable and interrupt_valid are ignored outside IDLE. Dropping irq_enable mid-sequence does not abort.
- interrupt_valid with irq_enable=0: no ack; the request stays pending at the PIC.
- Reset mid-sequence returns to IDLE immediately. An acked vector in flight is discarded, and any outstanding memory response is the memory side's responsibility.
- Minimum latency with zero-wait memory and always-ready CPU, cycle 0 = valid&enable sampled:
  - ack at cycle 1
  - IP request at cycle 2, response accepted at cycle 3
  - CS request at cycle 4, response accepted at cycle 5
  - result valid at cycle 6
- Single outstanding memory transaction at any time.

Test Plan:
- Vector 0x08, IVT word@0x20=0x1234, @0x22=0xF000, zero-wait -> one ack pulse; request addresses 0x00020 then 0x00022; result tdata=0x08_F000_1234 at cycle 6.
- Vector 0x09 with irq_enable=0 for 10 cycles, then 1 -> no ack during the 10 cycles; ack the cycle after enable rises; address 0x00024.
- Vector 0x70 with m_axis_mem_req_tready low 3 cycles and s_axis_mem_res_tvalid delayed 2 cycles -> address 0x001C0 held stable; no second request before the response; correct result.
- m_axis_intr_tready low 5 cycles while the PIC reasserts valid (vector 0x09) -> result held; no ack until the result handshake completes, then the new vector is accepted.
- resetn pulsed low during RD_CS_RES -> all outputs 0 asynchronously; after release, a new vector 0x0C reads 0x00030/0x00032 normally.
- IVT_BASE=20'hFFFFC, vector 0x01 -> addresses 0x00000 and 0x00002 (wrap-around).
